alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Command-issue stage that feeds the team's 4-bit combinational ALU and consumes its result.
- Accepts ALU commands through a valid/ready FIFO and reads operands from a 4x4-bit register file.
- Drives the ALU's A, B and sel inputs from registers, then writes the ALU result and carry back into the register file.
- Executes one command at a time, with no overlap, so there are no data hazards.

Parameters:
- FIFO_DEPTH, 4, number of buffered commands; must be a power of 2 and at least 2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command; equals not-full
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT; 111 = LDI (load immediate)
- cmd_dst  in  2  destination register index
- cmd_src_a  in  2  operand A register index
- cmd_src_b  in  2  operand B register index
- cmd_imm  in  4  immediate value, used only by LDI
- alu_a  out  4  registered operand A to the ALU
- alu_b  out  4  registered operand B to the ALU
- alu_sel  out  3  registered opcode to the ALU
- alu_result  in  4  ALU result (combinational return)
- alu_carry  in  1  ALU carry/borrow
- rd_addr  in  2  debug read address
- rd_data  out  4  combinational read of reg[rd_addr]
- carry_flag  out  1  carry from the last ADD or SUB
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty
- done  out  1  one-cycle pulse when a command retires

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; pointers and count cleared.
  - All four registers cleared to 0.
  - alu_a, alu_b and alu_sel set to 0.
  - carry_flag, done and busy set to 0; FSM goes to IDLE.
  - Reset mid-command abandons the command with no writeback.
- FIFO:
  - Push when cmd_valid and cmd_ready.
  - cmd_ready is low when count equals FIFO_DEPTH, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, EXEC, DONE.
- IDLE, FIFO non-empty:
  - Pop the head and latch dst into the issue register.
  - ALU op: alu_a <= reg[src_a], alu_b <= reg[src_b], alu_sel <= op; go to EXEC.
  - LDI: reg[dst] <= imm; go to DONE; alu_* hold their values.
- IDLE, FIFO empty: stay in IDLE.
- EXEC (1 cycle):
  - reg[dst] <= alu_result.
  - If alu_sel is 000 or 001, carry_flag <= alu_carry; otherwise carry_flag holds.
  - Go to DONE.
- DONE (1 cycle):
  - done = 1, decoded from state.
  - Return to IDLE; no pop occurs in DONE.
- Latency from pop: ALU op retires in 3 cycles (IDLE, EXEC, DONE); LDI in 2 cycles.
- Throughput: at most one command per 3 cycles for ALU ops, one per 2 cycles for LDI.
- alu_* outputs hold their last issued values between commands.
- Opcodes 101 and 110 are issued unchanged; the ALU returns 0, which is written to dst.
- dst may equal src_a or src_b: operands were captured at issue, so the writeback is safe.
- Consecutive dependent commands see the prior writeback, because writeback precedes the next pop.
- rd_data reflects register writes from the next cycle onward; there is no bypass.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero_flag (1 bit, reset 0).
  - Updated at every writeback (EXEC or LDI) to (written value == 0).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, LDI r0=9, LDI r1=8, ADD r2=r0+r1 -> alu_a=9, alu_b=8, alu_sel=000 during EXEC; r2=1; carry_flag=1; done pulses 3 times.
- r0=3, r1=5, SUB r3=r0-r1 -> r3=14 (0xE), carry_flag=1; then AND r0=r0&r1 -> r0=1, carry_flag stays 1.
- Push 4 commands while the FSM is busy -> cmd_ready=0 after the 4th; a 5th push is refused; all 4 retire in order; cmd_ready returns high after the first pop.
- NOT r1=~r1 with r1=5 -> r1=10 (0xA); opcode 101 with dst=r2 -> r2=0.
- Assert rst during EXEC of ADD r2 -> r2 stays 0, FIFO is empty, no done pulse, busy=0 the next cycle.
- With ALU_ZERO_FLAG_EN defined: r0=4, r1=4, SUB r2 -> zero_flag=1; then LDI r3=7 -> zero_flag=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: command FIFO, 4x4 register file and issue FSM for the 4-bit ALU.
// Optional: define ALU_ZERO_FLAG_EN to add the zero_flag output.
module alu_issue_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_dst,
   input  logic [1:0] cmd_src_a,
   input  logic [1:0] cmd_src_b,
   input  logic [3:0] cmd_imm,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [3:0] alu_result,
   input  logic       alu_carry,
   input  logic [1:0] rd_addr,
   output logic [3:0] rd_data,
   output logic       carry_flag,
   output logic       busy,
`ifdef ALU_ZERO_FLAG_EN
   output logic       zero_flag,
`endif
   output logic       done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [2:0] OP_LDI = 3'b111;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] dst;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [3:0] imm;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   state_t          state;
   state_t          state_nx;
   cmd_t            fifo_mem [FIFO_DEPTH];
   cmd_t            head;
   cmd_t            cmd_in;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic [3:0]      regs [4];
   logic [1:0]      dst_q;

   assign cmd_in    = '{op: cmd_op, dst: cmd_dst, sa: cmd_src_a,
                        sb: cmd_src_b, imm: cmd_imm};
   assign head      = fifo_mem[rd_ptr];
   assign cmd_ready = (count != CW'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE) || (count != '0);
   assign rd_data   = regs[rd_addr];

   // FIFO storage: written on every accepted push, never cleared
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_in;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state, pop request and done pulse
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               pop      = 1'b1;
               state_nx = (head.op == OP_LDI) ? DONE : EXEC;
            end
         end
         EXEC: state_nx = DONE;
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // issue registers, register-file writeback and flags
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_sel    <= '0;
         dst_q      <= '0;
         carry_flag <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
         zero_flag  <= 1'b0;
`endif
      end else begin
         if (pop) begin
            dst_q <= head.dst;
            if (head.op == OP_LDI) begin
               regs[head.dst] <= head.imm;
`ifdef ALU_ZERO_FLAG_EN
               zero_flag <= (head.imm == 4'd0);
`endif
            end else begin
               alu_a   <= regs[head.sa];
               alu_b   <= regs[head.sb];
               alu_sel <= head.op;
            end
         end
         if (state == EXEC) begin
            regs[dst_q] <= alu_result;
            if (alu_sel == 3'b000 || alu_sel == 3'b001)
               carry_flag <= alu_carry;
`ifdef ALU_ZERO_FLAG_EN
            zero_flag <= (alu_result == 4'd0);
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench with an ALU stub and a program-order model.
// Define ALU_ZERO_FLAG_EN to also check zero_flag.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [1:0] cmd_dst = '0;
   logic [1:0] cmd_src_a = '0;
   logic [1:0] cmd_src_b = '0;
   logic [3:0] cmd_imm = '0;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_result;
   logic       alu_carry;
   logic [1:0] rd_addr;
   logic [3:0] rd_data;
   logic       carry_flag;
   logic       busy;
   logic       done;
`ifdef ALU_ZERO_FLAG_EN
   logic       zero_flag;
`endif

   logic [1:0] main_addr = '0;
   logic [1:0] mon_addr = '0;
   logic       mon_en = 1'b0;
   assign rd_addr = mon_en ? mon_addr : main_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_dst(cmd_dst),
      .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
      .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_carry(alu_carry),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .carry_flag(carry_flag), .busy(busy),
`ifdef ALU_ZERO_FLAG_EN
      .zero_flag(zero_flag),
`endif
      .done(done)
   );

   // the team's 4-bit ALU: {carry, result}; SUB carry is the borrow
   function automatic logic [4:0] alu_fn(input logic [2:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
      case (op)
         3'd0: return {1'b0, a} + {1'b0, b};
         3'd1: return {a < b, 4'(a - b)};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, ~a};
         default: return 5'd0;
      endcase
   endfunction

   always_comb {alu_carry, alu_result} = alu_fn(alu_sel, alu_a, alu_b);

   typedef struct {
      logic [1:0] dst;
      logic [3:0] val;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] sel;
      logic       c;
      logic       z;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_regs [4];
   logic [3:0] m_a;
   logic [3:0] m_b;
   logic [2:0] m_sel;
   logic       m_c;
   logic       m_z;

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      m_a = '0; m_b = '0; m_sel = '0; m_c = 1'b0; m_z = 1'b0;
   endtask

   // commands run strictly in acceptance order, so the model applies them at once
   task automatic model_cmd(input logic [2:0] op, input logic [1:0] d,
                            input logic [1:0] sa, input logic [1:0] sb_i,
                            input logic [3:0] imm);
      exp_t       e;
      logic [4:0] r;
      if (op == 3'b111) begin
         m_regs[d] = imm;
         m_z = (imm == 4'd0);
      end else begin
         m_a = m_regs[sa];
         m_b = m_regs[sb_i];
         m_sel = op;
         r = alu_fn(op, m_a, m_b);
         m_regs[d] = r[3:0];
         if (op == 3'd0 || op == 3'd1) m_c = r[4];
         m_z = (r[3:0] == 4'd0);
      end
      e.dst = d; e.val = m_regs[d];
      e.a = m_a; e.b = m_b; e.sel = m_sel;
      e.c = m_c; e.z = m_z;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [1:0] d,
                       input logic [1:0] sa, input logic [1:0] sb_i,
                       input logic [3:0] imm, input bit record);
      int w = 0;
      @(negedge clk);
      cmd_op = op; cmd_dst = d; cmd_src_a = sa;
      cmd_src_b = sb_i; cmd_imm = imm; cmd_valid = 1'b1;
      while (!cmd_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         chk("send_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      if (record) model_cmd(op, d, sa, sb_i, imm);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w = 0;
      @(negedge clk);
      while (busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (busy) chk("idle_timeout", 0, 1);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a,
                         input int exp);
      main_addr = a;
      #1 chk(name, int'(rd_data), exp);
   endtask

   // monitor: every done pulse retires the oldest expected command
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            n_done++;
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               mon_addr = e.dst;
               mon_en = 1'b1;
               #1;
               chk("wb_value", int'(rd_data), int'(e.val));
               chk("alu_a", int'(alu_a), int'(e.a));
               chk("alu_b", int'(alu_b), int'(e.b));
               chk("alu_sel", int'(alu_sel), int'(e.sel));
               chk("carry_flag", int'(carry_flag), int'(e.c));
`ifdef ALU_ZERO_FLAG_EN
               chk("zero_flag", int'(zero_flag), int'(e.z));
`endif
               mon_en = 1'b0;
            end
         end
      end
   end

   initial begin
      int d0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_sel", int'(alu_sel), 0);
      chk("rst_carry", int'(carry_flag), 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) rd_chk("rst_reg", 2'(i), 0);

      // LDI r0=9, LDI r1=8, ADD r2=r0+r1
      d0 = n_done;
      send(3'd7, 2'd0, 2'd0, 2'd0, 4'd9, 1);
      send(3'd7, 2'd1, 2'd0, 2'd0, 4'd8, 1);
      send(3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1);
      wait_idle();
      rd_chk("add_r2", 2'd2, 1);
      chk("add_carry", int'(carry_flag), 1);
      chk("add_alu_a", int'(alu_a), 9);
      chk("add_alu_b", int'(alu_b), 8);
      chk("add_done_cnt", n_done - d0, 3);

      // SUB with borrow, then AND keeps carry
      send(3'd7, 2'd0, 2'd0, 2'd0, 4'd3, 1);
      send(3'd7, 2'd1, 2'd0, 2'd0, 4'd5, 1);
      send(3'd1, 2'd3, 2'd0, 2'd1, 4'd0, 1);
      send(3'd2, 2'd0, 2'd0, 2'd1, 4'd0, 1);
      wait_idle();
      rd_chk("sub_r3", 2'd3, 14);
      rd_chk("and_r0", 2'd0, 1);
      chk("and_carry_hold", int'(carry_flag), 1);

      // fill the FIFO behind a running ALU op
      for (int i = 0; i < 6; i++)
         send(3'($urandom_range(0, 4)), 2'($urandom),
              2'($urandom), 2'($urandom), 4'($urandom), 1);
      @(negedge clk);
      chk("full_ready", int'(cmd_ready), 0);
      cmd_op = 3'd7; cmd_dst = 2'd3; cmd_imm = 4'd15; cmd_valid = 1'b1;
      @(negedge clk);
      chk("refused_ready", int'(cmd_ready), 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("ready_after_pop", int'(cmd_ready), 1);
      chk("busy_full", int'(busy), 1);
      wait_idle();

      // NOT and unassigned opcode 101
      send(3'd7, 2'd1, 2'd0, 2'd0, 4'd5, 1);
      send(3'd4, 2'd1, 2'd1, 2'd0, 4'd0, 1);
      send(3'd7, 2'd2, 2'd0, 2'd0, 4'd6, 1);
      send(3'd5, 2'd2, 2'd0, 2'd1, 4'd0, 1);
      wait_idle();
      rd_chk("not_r1", 2'd1, 10);
      rd_chk("op5_r2", 2'd2, 0);

      // reset during EXEC of ADD r2
      send(3'd7, 2'd0, 2'd0, 2'd0, 4'd9, 1);
      send(3'd7, 2'd1, 2'd0, 2'd0, 4'd8, 1);
      send(3'd7, 2'd2, 2'd0, 2'd0, 4'd0, 1);
      wait_idle();
      d0 = n_done;
      send(3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(cmd_ready), 1);
      chk("abort_carry", int'(carry_flag), 0);
      rd_chk("abort_r2", 2'd2, 0);
      rd_chk("abort_r0", 2'd0, 0);
      @(negedge clk);
      chk("abort_busy2", int'(busy), 0);
      chk("abort_no_done", n_done - d0, 0);

`ifdef ALU_ZERO_FLAG_EN
      send(3'd7, 2'd0, 2'd0, 2'd0, 4'd4, 1);
      send(3'd7, 2'd1, 2'd0, 2'd0, 4'd4, 1);
      send(3'd1, 2'd2, 2'd0, 2'd1, 4'd0, 1);
      wait_idle();
      chk("zero_set", int'(zero_flag), 1);
      send(3'd7, 2'd3, 2'd0, 2'd0, 4'd7, 1);
      wait_idle();
      chk("zero_clr", int'(zero_flag), 0);
`endif

      // random traffic with idle gaps
      for (int i = 0; i < 300; i++) begin
         send(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom),
              2'($urandom), 4'($urandom), 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_idle();
      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
